// File: rtl/proc_frame_sched.sv
// ---------------------------------------------------------------------------
// proc_frame_sched
// Frame-level sequencer for the pixel datapath (bypass / invert / 3x3 conv).
// A config master writes shadow mode and kernel registers. The shadow values
// reach the datapath only at a frame boundary, and only after every pixel
// already in the pipeline has left it. This keeps each frame on one config.
//
// Ports
//   clk, rstn        processing clock, asynchronous active-low reset
//   cfg_wr_en        config write strobe
//   cfg_addr         0-8 kernel byte k, 9 mode, 10 control, 11-15 ignored
//   cfg_wr_data      config write data
//   in_valid/ready   datapath input handshake
//   out_valid/ready  datapath output handshake
//   mode             applied mode: 00 bypass, 01 invert, 10 conv
//   kernel           applied kernel; coeff k sits at [8k+7:8k]
//   proc_en          datapath may accept pixels (high only in RUN)
//   frame_done       one-cycle pulse after the last pixel of a frame
//   frame_cnt        completed frames, wraps
//   cfg_pending      committed shadow config not yet applied
//   cfg_err          sticky: illegal mode write or handshake violation
//   drain_to         sticky: drain gave up waiting for the pipeline
// ---------------------------------------------------------------------------
module proc_frame_sched #(
    parameter int IMG_W         = 32,
    parameter int IMG_H         = 32,
    parameter int INFLIGHT_W    = 8,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cfg_wr_en,
    input  logic [3:0]  cfg_addr,
    input  logic [7:0]  cfg_wr_data,
    input  logic        in_valid,
    input  logic        in_ready,
    input  logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  mode,
    output logic [71:0] kernel,
    output logic        proc_en,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic        cfg_pending,
    output logic        cfg_err,
    output logic        drain_to
);
    localparam int FRAME_PIX = IMG_W * IMG_H;
    localparam int PIX_W     = $clog2(FRAME_PIX);
    localparam int TO_W      = $clog2(DRAIN_TIMEOUT);
    localparam logic [PIX_W-1:0]      PIX_LAST  = PIX_W'(FRAME_PIX - 1);
    localparam logic [TO_W-1:0]       TO_LAST   = TO_W'(DRAIN_TIMEOUT - 1);
    localparam logic [INFLIGHT_W-1:0] INFL_MAX  = {INFLIGHT_W{1'b1}};
    localparam logic [INFLIGHT_W-1:0] INFL_ZERO = {INFLIGHT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t                r_state;
    logic [1:0]            r_sh_mode;
    logic [71:0]           r_sh_kernel;
    logic                  r_stop_req;
    logic [INFLIGHT_W-1:0] r_inflight;
    logic [PIX_W-1:0]      r_pix_cnt;
    logic [TO_W-1:0]       r_to_cnt;

    logic w_ctl_wr, w_start, w_commit, w_stop, w_clr;
    logic w_mode_wr, w_mode_bad;
    logic w_in_fire, w_out_fire, w_in_ok, w_out_ok, w_in_bad, w_out_bad, w_sat;
    logic w_last_pix, w_reconf, w_timeout, w_new_err;
    logic [INFLIGHT_W-1:0] w_inflight_nxt;

    assign w_ctl_wr   = cfg_wr_en & (cfg_addr == 4'd10);
    assign w_start    = w_ctl_wr & cfg_wr_data[0];
    assign w_commit   = w_ctl_wr & cfg_wr_data[1];
    assign w_stop     = w_ctl_wr & cfg_wr_data[2];
    assign w_clr      = w_ctl_wr & cfg_wr_data[3];
    assign w_mode_wr  = cfg_wr_en & (cfg_addr == 4'd9);
    assign w_mode_bad = w_mode_wr & (cfg_wr_data[1:0] == 2'b11);

    // Only legal handshakes move the in-flight count; illegal ones raise cfg_err
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;
    assign w_in_ok    = w_in_fire & proc_en;
    assign w_out_ok   = w_out_fire & (r_inflight != INFL_ZERO);
    assign w_in_bad   = w_in_fire & ~proc_en;
    assign w_out_bad  = w_out_fire & (r_inflight == INFL_ZERO);
    assign w_sat      = w_in_ok & ~w_out_ok & (r_inflight == INFL_MAX);
    assign w_new_err  = w_mode_bad | w_in_bad | w_out_bad | w_sat;

    // A commit or stop arriving with the last pixel still counts for this boundary
    assign w_last_pix = w_in_ok & (r_state == ST_RUN) & (r_pix_cnt == PIX_LAST);
    assign w_reconf   = cfg_pending | w_commit | r_stop_req | w_stop;
    assign w_timeout  = (r_state == ST_DRAIN) & (w_inflight_nxt != INFL_ZERO) & (r_to_cnt == TO_LAST);

    // Next in-flight count; holds at the maximum instead of wrapping
    always_comb begin
        w_inflight_nxt = r_inflight;
        if (w_in_ok && !w_out_ok) begin
            if (r_inflight != INFL_MAX) begin
                w_inflight_nxt = r_inflight + 1'b1;
            end else begin
                w_inflight_nxt = r_inflight;
            end
        end else if (w_out_ok && !w_in_ok) begin
            w_inflight_nxt = r_inflight - 1'b1;
        end else begin
            w_inflight_nxt = r_inflight;
        end
    end

    // Shadow config, never visible to the datapath until APPLY
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sh_mode   <= 2'b00;
            r_sh_kernel <= 72'd0;
        end else begin
            for (int k = 0; k < 9; k++) begin
                if (cfg_wr_en && (cfg_addr == 4'(k))) begin
                    r_sh_kernel[8*k +: 8] <= cfg_wr_data;
                end
            end
            if (w_mode_wr && !w_mode_bad) begin
                r_sh_mode <= cfg_wr_data[1:0];
            end
        end
    end

    // Sticky flags; a new event in the same cycle as a clear keeps the flag set
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cfg_err  <= 1'b0;
            drain_to <= 1'b0;
        end else begin
            cfg_err  <= (cfg_err & ~w_clr) | w_new_err;
            drain_to <= (drain_to & ~w_clr) | w_timeout;
        end
    end

    // Pipeline occupancy, pixel position within the frame and frame counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_inflight <= INFL_ZERO;
            r_pix_cnt  <= {PIX_W{1'b0}};
            frame_done <= 1'b0;
            frame_cnt  <= 16'd0;
        end else begin
            // A timed-out drain abandons whatever the pipeline still holds
            r_inflight <= w_timeout ? INFL_ZERO : w_inflight_nxt;
            frame_done <= w_last_pix;
            if (w_last_pix) begin
                r_pix_cnt <= {PIX_W{1'b0}};
                frame_cnt <= frame_cnt + 16'd1;
            end else if (w_in_ok) begin
                r_pix_cnt <= r_pix_cnt + 1'b1;
            end
        end
    end

    // Frame sequencer: state, proc_en, applied config and pending requests
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            proc_en     <= 1'b0;
            mode        <= 2'b00;
            kernel      <= 72'd0;
            cfg_pending <= 1'b0;
            r_stop_req  <= 1'b0;
            r_to_cnt    <= {TO_W{1'b0}};
        end else begin
            if (w_commit) cfg_pending <= 1'b1;
            if (w_stop)   r_stop_req  <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) r_state <= ST_APPLY;
                end
                ST_APPLY: begin
                    mode        <= r_sh_mode;
                    kernel      <= r_sh_kernel;
                    // A request written during APPLY is kept for the next boundary
                    cfg_pending <= w_commit;
                    r_stop_req  <= w_stop;
                    if (r_stop_req) begin
                        r_state <= ST_IDLE;
                        proc_en <= 1'b0;
                    end else begin
                        r_state <= ST_RUN;
                        proc_en <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_last_pix && w_reconf) begin
                        r_state  <= ST_DRAIN;
                        proc_en  <= 1'b0;
                        r_to_cnt <= {TO_W{1'b0}};
                    end
                end
                ST_DRAIN: begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                    // Leave as soon as the last outstanding pixel is leaving
                    if (w_timeout || (w_inflight_nxt == INFL_ZERO)) begin
                        r_state <= ST_APPLY;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    proc_en <= 1'b0;
                end
            endcase
        end
    end
endmodule
